// File: rtl/seg_bcd_scan.sv
// seg_bcd_scan: converts three 8-bit fields to decimal with a shared-timing
// double-dabble engine and scans them onto six multiplexed 7-segment digits.
module seg_bcd_scan #(
   parameter int SCAN_DIV       = 50000,
   parameter bit SEG_ACTIVE_LOW = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [23:0] data_in,
   output logic        busy,
   output logic [2:0]  sel,
   output logic [7:0]  seg
);
   localparam int         DW    = $clog2(SCAN_DIV);
   localparam logic [3:0] DASH  = 4'hA;
   localparam logic [3:0] BLANK = 4'hF;
   localparam logic [7:0] OFF   = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

   typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;
   state_t state, state_nx;

   logic [2:0][7:0]  bin;
   logic [2:0][11:0] bcd;
   logic [2:0]       cnt;
   logic [23:0]      last_data;
   logic             pending, start;
   logic [5:0][3:0]  dig;
   logic [DW-1:0]    div;
   logic [2:0]       sel_nx;
   logic [7:0]       pat;

   function automatic logic [11:0] adj(input logic [11:0] b);
      logic [11:0] r;
      r = '0;
      for (int i = 0; i < 3; i++)
         r[4*i +: 4] = b[4*i +: 4] >= 4'd5 ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
      return r;
   endfunction

   // Active-low patterns, dp off; codes 10 and above cover DASH and BLANK
   function automatic logic [7:0] enc(input logic [3:0] d);
      case (d)
         4'd0: return 8'hC0;
         4'd1: return 8'hF9;
         4'd2: return 8'hA4;
         4'd3: return 8'hB0;
         4'd4: return 8'h99;
         4'd5: return 8'h92;
         4'd6: return 8'h82;
         4'd7: return 8'hF8;
         4'd8: return 8'h80;
         4'd9: return 8'h90;
         DASH: return 8'hBF;
         default: return 8'hFF;
      endcase
   endfunction

   always_comb begin
      start    = state == IDLE && (pending || data_in != last_data);
      state_nx = state == IDLE  ? (start ? SHIFT : IDLE) :
                 state == SHIFT ? (cnt == 3'd7 ? COMMIT : SHIFT) : IDLE;
      sel_nx   = sel == 3'd5 ? 3'd0 : sel + 3'd1;
      pat      = enc(dig[sel_nx]) & ((sel_nx == 3'd1 || sel_nx == 3'd3) ? 8'h7F : 8'hFF);
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy      <= 1'b0;
         cnt       <= '0;
         bin       <= '0;
         bcd       <= '0;
         last_data <= '0;
         pending   <= 1'b1;
         dig       <= {6{BLANK}};
      end else begin
         if (start) begin
            bin       <= data_in;
            bcd       <= '0;
            last_data <= data_in;
            pending   <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b1;
         end
         if (state == SHIFT) begin
            cnt <= cnt + 3'd1;
            for (int i = 0; i < 3; i++)
               {bcd[i], bin[i]} <= {adj(bcd[i]), bin[i]} << 1;
         end
         // Field i owns digit slots 4-2i (tens) and 5-2i (ones)
         if (state == COMMIT) begin
            busy <= 1'b0;
            for (int i = 0; i < 3; i++) begin
               dig[4-2*i] <= bcd[i][11:8] != 0 ? DASH :
                             bcd[i][7:4] == 0 ? BLANK : bcd[i][7:4];
               dig[5-2*i] <= bcd[i][11:8] != 0 ? DASH : bcd[i][3:0];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div <= '0;
         sel <= '0;
         seg <= OFF;
      end else if (div == DW'(SCAN_DIV - 1)) begin
         div <= '0;
         sel <= sel_nx;
         seg <= SEG_ACTIVE_LOW ? pat : ~pat;
      end else begin
         div <= div + 1'b1;
      end
   end
endmodule
